// File: rtl/ram_pkg.sv
// Shared types and constants for the SPRAM read-modify-write bridge.
package ram_pkg;

  localparam int RAM_ADDR_WIDTH = 15;
  localparam int RAM_DATA_WIDTH = 32;

  localparam logic [3:0] STRB_NONE = 4'b0000;
  localparam logic [3:0] STRB_FULL = 4'b1111;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    WRITEBACK,
    RESP
  } state_t;

endpackage

// File: rtl/byte_merge.sv
// Byte-lane merge: strobed lanes come from new_word, the rest keep old_word.
module byte_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_word,
  input  logic [DATA_WIDTH-1:0]   new_word,
  input  logic [DATA_WIDTH/8-1:0] strb,
  output logic [DATA_WIDTH-1:0]   merged
);

  always_comb begin
    merged = old_word;
    for (int i = 0; i < DATA_WIDTH / 8; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/ram_rmw_controller.sv
// CPU valid/ready bus to single-port RAM bridge; partial writes become
// read-modify-write because the RAM itself has no byte enables.
module ram_rmw_controller
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = RAM_DATA_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    memValid,
  input  logic [31:0]             memAddress,
  input  logic [DATA_WIDTH-1:0]   memWdata,
  input  logic [DATA_WIDTH/8-1:0] memWstrb,
  output logic                    memReady,
  output logic [DATA_WIDTH-1:0]   memRdata,
  output logic                    ramWriteEnable,
  output logic [ADDR_WIDTH-1:0]   ramAddress,
  output logic [DATA_WIDTH-1:0]   ramDataIn,
  input  logic [DATA_WIDTH-1:0]   ramDataOut
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  state_t state;
  state_t next_state;

  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [STRB_WIDTH-1:0] req_wstrb;
  logic [DATA_WIDTH-1:0] merged;
  logic                  accept;
  logic                  unused_addr_bits;

  // Word index only; byte offset and bits above the RAM size are decoded upstream.
  assign unused_addr_bits = ^{memAddress[31:ADDR_WIDTH+2], memAddress[1:0]};
  assign accept = (state == IDLE) && memValid;

  byte_merge #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_byte_merge (
    .old_word(ramDataOut),
    .new_word(req_wdata),
    .strb    (req_wstrb),
    .merged  (merged)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (memValid) next_state = ISSUE;
      ISSUE:     next_state = (req_wstrb == STRB_FULL) ? RESP : CAPTURE;
      CAPTURE:   next_state = (req_wstrb == STRB_NONE) ? RESP : WRITEBACK;
      WRITEBACK: next_state = RESP;
      RESP:      next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Request capture: contents are don't-care until the next accept.
  always_ff @(posedge clock) begin
    if (accept) begin
      req_addr  <= memAddress[ADDR_WIDTH+1:2];
      req_wdata <= memWdata;
      req_wstrb <= memWstrb;
    end
  end

  // RAM address is loaded at accept and held through CAPTURE, since the
  // RAM output bank mux decodes it combinationally.
  always_ff @(posedge clock) begin
    if (reset) begin
      memReady   <= 1'b0;
      memRdata   <= '0;
      ramAddress <= '0;
      ramDataIn  <= '0;
    end else begin
      memReady <= (next_state == RESP);
      if (accept) begin
        ramAddress <= memAddress[ADDR_WIDTH+1:2];
        ramDataIn  <= memWdata;
      end
      if (state == CAPTURE) begin
        if (req_wstrb == STRB_NONE) memRdata  <= ramDataOut;
        else                        ramDataIn <= merged;
      end
    end
  end

  // Reset gates the strobe directly so an in-flight write never lands.
  assign ramWriteEnable = ((state == ISSUE && req_wstrb == STRB_FULL) ||
                           state == WRITEBACK) && !reset;

endmodule

// File: tb/tb_ram_rmw_controller.sv
// Directed bench for ram_rmw_controller with a behavioural one-cycle SPRAM.
module tb_ram_rmw_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        memValid;
  logic [31:0] memAddress;
  logic [31:0] memWdata;
  logic [3:0]  memWstrb;
  logic        memReady;
  logic [31:0] memRdata;
  logic        ramWriteEnable;
  logic [14:0] ramAddress;
  logic [31:0] ramDataIn;
  logic [31:0] ramDataOut;

  always #5 clock = ~clock;

  ram_rmw_controller dut (
    .clock         (clock),
    .reset         (reset),
    .memValid      (memValid),
    .memAddress    (memAddress),
    .memWdata      (memWdata),
    .memWstrb      (memWstrb),
    .memReady      (memReady),
    .memRdata      (memRdata),
    .ramWriteEnable(ramWriteEnable),
    .ramAddress    (ramAddress),
    .ramDataIn     (ramDataIn),
    .ramDataOut    (ramDataOut)
  );

  // SPRAM model: registered read data, available one cycle after the address edge.
  logic [31:0] mem [0:32767];
  logic [31:0] ram_q;
  always @(posedge clock) begin
    if (ramWriteEnable) mem[ramAddress] <= ramDataIn;
    ram_q <= mem[ramAddress];
  end
  assign ramDataOut = ram_q;

  int          we_count  = 0;
  int          rdy_count = 0;
  logic [31:0] we_data_last;
  logic [14:0] we_addr_last;
  always @(negedge clock) begin
    if (ramWriteEnable) begin
      we_count++;
      we_data_last = ramDataIn;
      we_addr_last = ramAddress;
    end
    if (memReady) rdy_count++;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Waits for memReady, counting cycles from the next (acceptance) edge.
  task automatic wait_ready(output int lat);
    lat = 0;
    do begin
      @(posedge clock); #1;
      lat++;
    end while (!memReady && lat < 20);
    check("ready_seen", {31'd0, memReady}, 32'd1);
  endtask

  // One transaction; inputs are scrambled after acceptance to prove they are ignored.
  task automatic do_txn(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s,
                        output int lat, output logic [31:0] rdata, output logic [14:0] raddr);
    @(negedge clock);
    memValid = 1'b1; memAddress = a; memWdata = w; memWstrb = s;
    @(posedge clock); #1;
    lat = 1;
    memAddress = $urandom; memWdata = $urandom; memWstrb = 4'($urandom);
    while (!memReady && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    check("ready_seen", {31'd0, memReady}, 32'd1);
    rdata = memRdata;
    raddr = ramAddress;
    memValid = 1'b0;
    @(posedge clock); #1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          exp_lat;
    int          exp_we;
    logic [31:0] exp_we_data;
    logic [14:0] exp_ram_addr;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [17];

  initial begin
    int          lat;
    int          we0;
    int          rdy0;
    logic [31:0] rdata;
    logic [14:0] raddr;
    logic [31:0] b2b_exp [3];

    vecs[0]  = '{32'h0000_0010, 32'hDEADBEEF, 4'b1111, 2, 1, 32'hDEADBEEF, 15'h0004, 32'h0};
    vecs[1]  = '{32'h0000_0010, 32'h0,        4'b0000, 3, 0, 32'h0,        15'h0004, 32'hDEADBEEF};
    vecs[2]  = '{32'h0000_0010, 32'h11223344, 4'b0101, 4, 1, 32'hDE22BE44, 15'h0004, 32'hDEADBEEF};
    vecs[3]  = '{32'h0000_0010, 32'h0,        4'b0000, 3, 0, 32'h0,        15'h0004, 32'hDE22BE44};
    vecs[4]  = '{32'h0000_FFFC, 32'hA5A5A5A5, 4'b1111, 2, 1, 32'hA5A5A5A5, 15'h3FFF, 32'hDE22BE44};
    vecs[5]  = '{32'h0001_0000, 32'h5A5A5A5A, 4'b1111, 2, 1, 32'h5A5A5A5A, 15'h4000, 32'hDE22BE44};
    vecs[6]  = '{32'h0000_FFFC, 32'h0,        4'b0000, 3, 0, 32'h0,        15'h3FFF, 32'hA5A5A5A5};
    vecs[7]  = '{32'h0001_0000, 32'h0,        4'b0000, 3, 0, 32'h0,        15'h4000, 32'h5A5A5A5A};
    vecs[8]  = '{32'h0002_0010, 32'h0,        4'b0000, 3, 0, 32'h0,        15'h0004, 32'hDE22BE44};
    vecs[9]  = '{32'h0000_0000, 32'hAABBCCDD, 4'b1111, 2, 1, 32'hAABBCCDD, 15'h0000, 32'hDE22BE44};
    vecs[10] = '{32'h0000_0003, 32'h00000011, 4'b0001, 4, 1, 32'hAABBCC11, 15'h0000, 32'hDE22BE44};
    vecs[11] = '{32'h0000_0004, 32'h11111111, 4'b1111, 2, 1, 32'h11111111, 15'h0001, 32'hDE22BE44};
    vecs[12] = '{32'h0000_0008, 32'h22222222, 4'b1111, 2, 1, 32'h22222222, 15'h0002, 32'hDE22BE44};
    vecs[13] = '{32'h0000_001C, 32'h01020304, 4'b1111, 2, 1, 32'h01020304, 15'h0007, 32'hDE22BE44};
    vecs[14] = '{32'h0000_0000, 32'h0,        4'b0000, 3, 0, 32'h0,        15'h0000, 32'hAABBCC11};
    vecs[15] = '{32'h0000_0004, 32'hCAFEF00D, 4'b1110, 4, 1, 32'hCAFEF011, 15'h0001, 32'hAABBCC11};
    vecs[16] = '{32'h0000_0004, 32'h0,        4'b0000, 3, 0, 32'h0,        15'h0001, 32'hCAFEF011};
    b2b_exp[0] = 32'hAABBCC11;
    b2b_exp[1] = 32'hCAFEF011;
    b2b_exp[2] = 32'h22222222;

    reset = 1'b1; memValid = 1'b0; memAddress = '0; memWdata = '0; memWstrb = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_memReady",       {31'd0, memReady},       32'd0);
    check("rst_memRdata",       memRdata,                32'd0);
    check("rst_ramWriteEnable", {31'd0, ramWriteEnable}, 32'd0);
    check("rst_ramAddress",     {17'd0, ramAddress},     32'd0);
    check("rst_ramDataIn",      ramDataIn,               32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < 17; i++) begin
      we0 = we_count;
      do_txn(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, lat, rdata, raddr);
      check($sformatf("v%0d_latency", i),  32'(lat),            32'(vecs[i].exp_lat));
      check($sformatf("v%0d_we_count", i), 32'(we_count - we0), 32'(vecs[i].exp_we));
      check($sformatf("v%0d_ramAddress", i), {17'd0, raddr},    {17'd0, vecs[i].exp_ram_addr});
      check($sformatf("v%0d_memRdata", i), rdata,               vecs[i].exp_rdata);
      if (vecs[i].exp_we != 0) begin
        check($sformatf("v%0d_we_data", i), we_data_last,           vecs[i].exp_we_data);
        check($sformatf("v%0d_we_addr", i), {17'd0, we_addr_last}, {17'd0, vecs[i].exp_ram_addr});
      end
    end

    // Back-to-back reads with memValid held high throughout.
    rdy0 = rdy_count;
    @(negedge clock);
    memValid = 1'b1; memWstrb = 4'b0000; memAddress = 32'h0;
    for (int k = 0; k < 3; k++) begin
      wait_ready(lat);
      check($sformatf("b2b%0d_latency", k), 32'(lat), 32'd3);
      check($sformatf("b2b%0d_memRdata", k), memRdata, b2b_exp[k]);
      memAddress = 32'(4 * (k + 1));
      if (k == 2) memValid = 1'b0;
      @(posedge clock); #1;
      check($sformatf("b2b%0d_idle_gap", k), {31'd0, memReady}, 32'd0);
    end
    @(posedge clock); #1;
    check("b2b_pulses", 32'(rdy_count - rdy0), 32'd3);

    // Reset in the CAPTURE cycle of a partial write to word 7.
    we0 = we_count; rdy0 = rdy_count;
    @(negedge clock);
    memValid = 1'b1; memAddress = 32'h1C; memWdata = 32'hFFFFFFFF; memWstrb = 4'b0011;
    @(posedge clock); #1;
    memValid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("rst_capture_memRdata", memRdata, 32'd0);
    repeat (5) @(posedge clock);
    #1;
    check("rst_capture_no_we",    32'(we_count - we0),   32'd0);
    check("rst_capture_no_ready", 32'(rdy_count - rdy0), 32'd0);
    do_txn(32'h1C, 32'h0, 4'b0000, lat, rdata, raddr);
    check("rst_capture_word7", rdata, 32'h01020304);

    // Reset during the ISSUE cycle of a full write.
    we0 = we_count; rdy0 = rdy_count;
    @(negedge clock);
    memValid = 1'b1; memAddress = 32'h1C; memWdata = 32'hBADBAD00; memWstrb = 4'b1111;
    @(posedge clock); #1;
    memValid = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_issue_we_forced_low", {31'd0, ramWriteEnable}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check("rst_issue_no_we",    32'(we_count - we0),   32'd0);
    check("rst_issue_no_ready", 32'(rdy_count - rdy0), 32'd0);
    do_txn(32'h1C, 32'h0, 4'b0000, lat, rdata, raddr);
    check("rst_issue_word7", rdata, 32'h01020304);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_rmw_controller.md
Name: ram_rmw_controller

Overview:
- Bridges the CPU native memory bus (valid/ready, byte address, 4-bit write strobes) to the 32-bit, 32K-word SPRAM block.
- The SPRAM has no byte write enables because its nibble masks are tied high, so partial writes are done here as read-modify-write.
- Sits directly upstream of the SPRAM. Drives its writeEnable/address/dataIn and consumes its dataOut, which is valid one cycle after the address edge.

Parameters:
- ADDR_WIDTH, 15, SPRAM word-address width. Bit ADDR_WIDTH-1 selects the upper bank.
- DATA_WIDTH, 32, bus/RAM data width. Fixed at 32; strobe width is DATA_WIDTH/8.

Ports:
- clock  input  1  single system clock, rising edge
- reset  input  1  synchronous, active-high reset
- memValid  input  1  request valid; held high until memReady
- memAddress  input  32  byte address; bits [ADDR_WIDTH+1:2] used, others ignored
- memWdata  input  32  write data
- memWstrb  input  4  byte strobes; 0000 = read
- memReady  output  1  single-cycle completion pulse
- memRdata  output  32  read data, valid when memReady on a read
- ramWriteEnable  output  1  to SPRAM writeEnable
- ramAddress  output  ADDR_WIDTH  to SPRAM address
- ramDataIn  output  32  to SPRAM dataIn
- ramDataOut  input  32  from SPRAM dataOut

Behaviour:
- Reset values: state IDLE; memReady, memRdata, ramWriteEnable, ramAddress and ramDataIn all 0. Register contents are discarded.
- Request capture: in IDLE with memValid=1, the edge registers reqAddr = memAddress[ADDR_WIDTH+1:2], reqWdata and reqWstrb, then moves to ISSUE.
- ramAddress = reqAddr from ISSUE through WRITEBACK. It is held stable through CAPTURE because the SPRAM output bank mux decodes the address combinationally.
- ramWriteEnable = (state==ISSUE && reqWstrb==1111 || state==WRITEBACK) && !reset.
- ramDataIn = reqWdata in ISSUE; merged word in WRITEBACK; otherwise unchanged.
- States and transitions:
  - IDLE -> ISSUE: on memValid.
  - ISSUE -> RESP: if wstrb==1111 (full write; data written at the end of ISSUE).
  - ISSUE -> CAPTURE: otherwise (read issued, WE=0).
  - CAPTURE, read (wstrb==0000): memRdata <= ramDataOut; -> RESP.
  - CAPTURE, partial write: merged <= per byte i, reqWstrb[i] ? reqWdata byte i : ramDataOut byte i; -> WRITEBACK.
  - WRITEBACK -> RESP: WE=1 with the merged word.
  - RESP: memReady=1 for exactly this cycle; -> IDLE.
- Latency from the acceptance edge to memReady high:
  - full write: 2 cycles
  - read: 3 cycles
  - partial write: 4 cycles
- Back-to-back: IDLE is always visited for one cycle after RESP, so memValid seen in the cycle after memReady starts the next request. No request is ever accepted while memReady=1.
- memRdata updates only on reads and holds its value otherwise, including across writes.
- memValid dropping mid-transaction is a protocol violation. The transaction completes anyway.
- memValid is not sampled outside IDLE. Changes to memAddress, memWdata or memWstrb after acceptance are ignored.
- Reset mid-operation: ramWriteEnable is forced to 0 in the reset cycle, so no write is issued. Next state is IDLE and any in-flight request is dropped without memReady.
- Address wrap: addresses beyond 2^(ADDR_WIDTH+2) bytes alias modulo the RAM size. Address decoding belongs upstream.
- Bank crossing needs no special handling: a single word never spans banks.

Decomposition:
- Package ram_pkg:
  - state enum: IDLE, ISSUE, CAPTURE, WRITEBACK, RESP
  - RAM_ADDR_WIDTH=15, RAM_DATA_WIDTH=32
  - STRB_NONE=4'b0000, STRB_FULL=4'b1111
- One sub-module, byte_merge: combinational merge of (old word, new word, strobes) into a word. Unit-testable on its own.
- The FSM and registers stay in ram_rmw_controller.

Test Plan:
- Reset then full write: reset held 2 cycles, then write addr 0x0000_0010, data 0xDEADBEEF, wstrb 1111. Expect ramWriteEnable=1 with ramAddress=4 for one cycle, memReady 2 cycles after acceptance. Reading addr 0x10 then returns 0xDEADBEEF on the 3rd cycle.
- Partial write: word 4 = 0xDEADBEEF; write data 0x11223344 with wstrb 0101. Expect one read cycle and one WE cycle with ramDataIn=0xDE22BE44, memReady 4 cycles after acceptance. A read returns 0xDE22BE44.
- Bank boundary: write 0xA5A5A5A5 to word 0x3FFF (byte 0xFFFC) and 0x5A5A5A5A to word 0x4000 (byte 0x10000). Each reads back its own value; ramAddress[14] toggles accordingly.
- Back-to-back: memValid held high across 3 reads of words 0, 1, 2. Exactly 3 memReady pulses, each followed by one IDLE cycle, with correct memRdata per pulse.
- Reset mid-RMW: assert reset in the CAPTURE cycle of a partial write to word 7 (prior value 0x01020304). No WE pulse and no memReady. A later read of word 7 returns 0x01020304.
- Read with wstrb 0000 after write: memRdata holds the previous read value during the write's memReady. It updates only on the read's memReady.
